// File: rtl/softmax_pkg.sv
// rtl/softmax_pkg.sv - shared types for the softmax sequencer
// Purpose: sequencer state encoding and shared-LUT select encoding.
// Ports: none (package).
package softmax_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    EXP      = 3'd1,
    DRAIN    = 3'd2,
    INV      = 3'd3,
    INV_WAIT = 3'd4,
    NORM     = 3'd5,
    OUT      = 3'd6
  } state_t;

  typedef enum logic {
    LUT_EXP = 1'b0,
    LUT_INV = 1'b1
  } lut_sel_t;

endpackage

// File: rtl/softmax_norm_mul.sv
// rtl/softmax_norm_mul.sv - exp * inverse, shift, saturate to signed max
// Purpose: combinational normalisation of one element.
// Ports:
//   exp_val : unsigned exp LUT value
//   inv_val : unsigned inverse LUT value
//   result  : (exp_val*inv_val)>>RES_SHIFT, clamped to the WIDTH-bit signed max
module softmax_norm_mul #(
  parameter int WIDTH     = 10,
  parameter int MEM_WIDTH = 10,
  parameter int RES_SHIFT = 5
) (
  input  logic [MEM_WIDTH-1:0] exp_val,
  input  logic [MEM_WIDTH-1:0] inv_val,
  output logic [WIDTH-1:0]     result
);

  localparam int PW = 2 * MEM_WIDTH;

  logic [PW-1:0] prod;
  logic [PW-1:0] shifted;
  logic          over;

  assign prod    = PW'(exp_val) * PW'(inv_val);
  assign shifted = prod >> RES_SHIFT;
  // Both operands are unsigned, so only the positive limit can be exceeded.
  assign over    = shifted > PW'({(WIDTH-1){1'b1}});
  assign result  = over ? {1'b0, {(WIDTH-1){1'b1}}} : shifted[WIDTH-1:0];

endmodule

// File: rtl/softmax_sequencer.sv
// rtl/softmax_sequencer.sv - softmax over one vector using a shared exp/inverse LUT
// Purpose: looks up exp of every element, sums them, looks up the inverse of
//   the sum, then scales each exp by that inverse.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   in_valid/in_ready   : input vector handshake, in_data = SIZE two's-complement elements
//   lut_req/lut_sel/    : shared LUT request (sel 0 = exp, 1 = inverse);
//   lut_addr/lut_data     lut_data returns one cycle after lut_req
//   out_valid/out_ready : result handshake, out_data = SIZE elements
//   flush               : synchronous abort back to IDLE
//   busy                : not IDLE
//   sat                 : inverse address saturated for the current vector
module softmax_sequencer
  import softmax_pkg::*;
#(
  parameter int WIDTH          = 10,
  parameter int NFRAC          = 5,
  parameter int SIZE           = 32,
  parameter int MEM_WIDTH      = 10,
  parameter int TABLE_SIZE_POW = 10,
  parameter int SUM_SHIFT      = 0,
  parameter int RES_SHIFT      = NFRAC
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [SIZE-1:0][WIDTH-1:0]      in_data,
  output logic                            lut_req,
  output logic                            lut_sel,
  output logic [TABLE_SIZE_POW-1:0]       lut_addr,
  input  logic [MEM_WIDTH-1:0]            lut_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [SIZE-1:0][WIDTH-1:0]      out_data,
  input  logic                            flush,
  output logic                            busy,
  output logic                            sat
);

  localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int SW = MEM_WIDTH + $clog2(SIZE);
  localparam int AW = (SW > TABLE_SIZE_POW) ? SW : TABLE_SIZE_POW;
  localparam logic [IW-1:0] LAST = IW'(SIZE - 1);

  state_t state, state_nx;

  logic [IW-1:0]                     idx;
  logic [SIZE-1:0][WIDTH-1:0]        in_buf;
  logic [SIZE-1:0][MEM_WIDTH-1:0]    exp_buf;
  logic [SIZE-1:0][WIDTH-1:0]        out_buf;
  logic [SW-1:0]                     sum;
  logic [MEM_WIDTH-1:0]              inv;
  logic                              sat_q;
  logic                              ov_q;
  // An exp request issued last cycle returns now; remember where it goes.
  logic                              exp_pend;
  logic [IW-1:0]                     exp_pend_idx;

  logic                              accept;
  logic [WIDTH-1:0]                  cur_in;
  logic [TABLE_SIZE_POW-1:0]         exp_addr;
  logic [AW-1:0]                     inv_full;
  logic                              inv_sat;
  logic [TABLE_SIZE_POW-1:0]         inv_addr;
  logic [WIDTH-1:0]                  norm_res;

  assign accept = (state == IDLE) && in_valid && !flush;
  assign cur_in = in_buf[idx];

  // The LUT is indexed by the top bits of the fixed-point input.
  generate
    if (WIDTH >= TABLE_SIZE_POW) begin : g_addr_msb
      assign exp_addr = cur_in[WIDTH-1 -: TABLE_SIZE_POW];
    end else begin : g_addr_pad
      assign exp_addr = {cur_in, {(TABLE_SIZE_POW-WIDTH){1'b0}}};
    end
  endgenerate

  assign inv_full = AW'(sum >> SUM_SHIFT);
  assign inv_sat  = inv_full > AW'({TABLE_SIZE_POW{1'b1}});
  assign inv_addr = inv_sat ? {TABLE_SIZE_POW{1'b1}} : inv_full[TABLE_SIZE_POW-1:0];

  softmax_norm_mul #(
    .WIDTH     (WIDTH),
    .MEM_WIDTH (MEM_WIDTH),
    .RES_SHIFT (RES_SHIFT)
  ) u_norm (
    .exp_val (exp_buf[idx]),
    .inv_val (inv),
    .result  (norm_res)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    lut_req  = 1'b0;
    lut_sel  = LUT_EXP;
    lut_addr = '0;
    case (state)
      IDLE:     if (in_valid) state_nx = EXP;
      EXP: begin
        lut_req  = 1'b1;
        lut_addr = exp_addr;
        if (idx == LAST) state_nx = DRAIN;
      end
      DRAIN:    state_nx = INV;
      INV: begin
        lut_req  = 1'b1;
        lut_sel  = LUT_INV;
        lut_addr = inv_addr;
        state_nx = INV_WAIT;
      end
      INV_WAIT: state_nx = NORM;
      NORM:     if (idx == LAST) state_nx = OUT;
      OUT:      if (ov_q && out_ready) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx          <= '0;
      in_buf       <= '0;
      exp_buf      <= '0;
      out_buf      <= '0;
      sum          <= '0;
      inv          <= '0;
      sat_q        <= 1'b0;
      ov_q         <= 1'b0;
      exp_pend     <= 1'b0;
      exp_pend_idx <= '0;
    end else begin
      exp_pend <= 1'b0;
      if (exp_pend) begin
        exp_buf[exp_pend_idx] <= lut_data;
        sum                   <= sum + SW'(lut_data);
      end
      case (state)
        IDLE: if (accept) begin
          in_buf <= in_data;
          sum    <= '0;
          idx    <= '0;
          sat_q  <= 1'b0;
        end
        EXP: begin
          exp_pend     <= 1'b1;
          exp_pend_idx <= idx;
          idx          <= (idx == LAST) ? '0 : idx + 1'b1;
        end
        INV: if (inv_sat) sat_q <= 1'b1;
        INV_WAIT: begin
          inv <= lut_data;
          idx <= '0;
        end
        NORM: begin
          out_buf[idx] <= norm_res;
          idx          <= (idx == LAST) ? '0 : idx + 1'b1;
        end
        default: ;
      endcase
      // out_valid is registered: it rises on the second OUT cycle, after
      // the last normalised element has settled in out_buf.
      ov_q <= (state == OUT) && !flush && !(ov_q && out_ready);
      if (flush) exp_pend <= 1'b0;
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = ov_q;
  assign out_data  = out_buf;
  assign sat       = sat_q;

endmodule

// File: doc/softmax_sequencer.md
SOFTMAX_SEQUENCER -- requirements
Module: softmax_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 10, the fixed-point data width.
REQ-002 SHALL have parameter NFRAC, default 5, the number of fractional bits.
REQ-003 SHALL have parameter SIZE, default 32, the number of elements per vector.
REQ-004 SHALL have parameter MEM_WIDTH, default 10, the LUT entry width (unsigned).
REQ-005 SHALL have parameter TABLE_SIZE_POW, default 10, the log2 of the LUT depth.
REQ-006 SHALL have parameter SUM_SHIFT, default 0, the right shift applied to the sum before inverse lookup.
REQ-007 SHALL have parameter RES_SHIFT, default NFRAC, the right shift applied to the exp*inv product.
REQ-008 SHALL have ports clk (in, 1, single clock) and reset_n (in, 1); reset is asynchronous and active-low.
REQ-009 SHALL have ports in_valid (in, 1), in_ready (out, 1) and in_data (in, SIZE x WIDTH signed), the input vector handshake.
REQ-010 SHALL have ports lut_req (out, 1), lut_sel (out, 1: 0=exp, 1=invert) and lut_addr (out, TABLE_SIZE_POW), the shared LUT request.
REQ-011 SHALL have port lut_data (in, MEM_WIDTH), valid exactly 1 cycle after lut_req.
REQ-012 SHALL have ports out_valid (out, 1), out_ready (in, 1) and out_data (out, SIZE x WIDTH signed), the result handshake.
REQ-013 SHALL have ports flush (in, 1, synchronous abort), busy (out, 1, state != IDLE) and sat (out, 1, sticky inverse-address saturation for the current vector).

Function
REQ-014 SHALL implement states IDLE, EXP, DRAIN, INV, INV_WAIT, NORM, OUT.
REQ-015 SHALL assert in_ready only in IDLE; on in_valid&&in_ready SHALL capture in_data, clear sum, idx and sat, and go to EXP.
REQ-016 EXP: each cycle SHALL drive lut_req=1, lut_sel=0 and lut_addr = in_buf[idx][WIDTH-1 -: TABLE_SIZE_POW] (zero-padded LSBs if WIDTH < TABLE_SIZE_POW), then increment idx; after issuing idx=SIZE-1 SHALL go to DRAIN.
REQ-017 Each returned exp lut_data SHALL be written to exp_buf[idx delayed 1] and added to an unsigned sum of width MEM_WIDTH+$clog2(SIZE) (no overflow possible).
REQ-018 DRAIN SHALL last 1 cycle (captures the last exp) and then go to INV.
REQ-019 INV SHALL drive lut_req=1, lut_sel=1 and lut_addr = sum>>SUM_SHIFT, saturated to 2**TABLE_SIZE_POW-1 (setting sat on saturation), then go to INV_WAIT.
REQ-020 INV_WAIT SHALL latch lut_data as inv, reset idx and go to NORM.
REQ-021 NORM: each cycle SHALL compute out_buf[idx] = (exp_buf[idx]*inv)>>RES_SHIFT, saturated to WIDTH-bit signed max, one element per cycle; after idx=SIZE-1 SHALL go to OUT.
REQ-022 OUT SHALL hold out_valid=1 with out_data stable until out_ready, then go to IDLE; with out_ready held high, out_valid SHALL last exactly 1 cycle.
REQ-023 Latency: out_valid SHALL rise 2*SIZE+4 rising edges after the accepting edge.
REQ-024 lut_req SHALL be 0 in every state other than EXP and INV; lut_addr and lut_sel SHALL then be 0.
REQ-025 flush SHALL return the block to IDLE on the next edge from any state, deassert out_valid and discard partial results; flush in IDLE SHALL be a no-op; flush SHALL take priority over simultaneous in_valid.
REQ-026 A new vector SHALL be accepted no earlier than the cycle after the OUT handshake (no overlap).

Reset
REQ-027 While reset_n=0, state SHALL be IDLE and in_ready=1; out_valid, lut_req, lut_sel, lut_addr, busy, sat and all out_data SHALL be 0.
REQ-028 Reset asserted mid-vector SHALL abandon the vector; no stale out_valid SHALL appear after release.

Structure
REQ-029 The state enum and the LUT select encoding (LUT_EXP=0, LUT_INV=1) SHALL be defined in a shared package softmax_pkg.
REQ-030 The multiply-shift-saturate SHALL be a sub-module softmax_norm_mul (combinational, MEM_WIDTH x MEM_WIDTH -> WIDTH).

Verification (SIZE=4, WIDTH=10, NFRAC=5, MEM_WIDTH=10, TABLE_SIZE_POW=10, 1-cycle bench LUT model)
REQ-031 Inputs all 0, exp LUT=16, inv LUT[64]=16 -> inv addr 64, out_data all 8, out_valid at edge 12 after accept.
REQ-032 Inputs {0,0,0,0}, exp LUT=1023, SUM_SHIFT=0 -> sum 4092, addr saturates to 1023, sat=1.
REQ-033 out_ready held 0 for 5 cycles in OUT -> out_valid and out_data stable, in_ready=0 throughout.
REQ-034 flush during NORM idx=2 -> IDLE next edge, in_ready=1, out_valid never asserted for that vector.
REQ-035 reset_n low during EXP -> all outputs 0 immediately; after release a fresh vector completes with correct results.
REQ-036 Exp LUT=1023, inv=1023, RES_SHIFT=0 -> out_data saturates to 511.
